// File: rtl/channel_frame_arbiter.sv
// Merges header/footer-delimited frames from CH_NUM trigger channels onto one AXI-Stream output.
// Round-robin grant per frame, single output register, watchdog truncation and stray-word draining.
module channel_frame_arbiter #(
  parameter int CH_NUM          = 4,
  parameter int DOUT_WIDTH      = 64,
  parameter int MAX_FRAME_WORDS = 210
) (
  input  logic                         M_AXIS_ACLK,
  input  logic                         M_AXIS_ARESETN,
  input  logic [CH_NUM*DOUT_WIDTH-1:0] CH_DOUT,
  input  logic [CH_NUM-1:0]            CH_VALID,
  output logic [CH_NUM-1:0]            CH_READY,
  input  logic [CH_NUM-1:0]            CH_ENABLE,
  output logic [DOUT_WIDTH-1:0]        M_AXIS_TDATA,
  output logic                         M_AXIS_TVALID,
  output logic                         M_AXIS_TLAST,
  input  logic                         M_AXIS_TREADY,
  output logic [2:0]                   GRANT_ID,
  output logic [31:0]                  FRAME_CNT,
  output logic [15:0]                  ERR_CNT
);

  localparam int         CNT_W = $clog2(MAX_FRAME_WORDS + 1);
  localparam logic [7:0] HDR   = 8'hAA;
  localparam logic [7:0] FTR   = 8'h55;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state, stateNext;
  logic [2:0]            grantId, grantNext;
  logic [CNT_W-1:0]      wordCnt, wordCntInc;
  logic [DOUT_WIDTH-1:0] tData_p1;
  logic                  tVld_p1, tLast_p1;
  logic [31:0]           frameCnt;
  logic [15:0]           errCnt;

  logic [CH_NUM-1:0]     isHdr, cand, candRot;
  logic [CH_NUM-1:0]     grantOneHot, strayOneHot, readyVec;
  logic                  anyCand, rrFound, strayHit, strayTake;
  logic [2:0]            rrPick, strayIdx;
  logic [DOUT_WIDTH-1:0] grantWord;
  logic                  grantValid, accept, isFooter, wdExpire;

  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  for (genvar g = 0; g < CH_NUM; g++) begin : gHdr
    assign isHdr[g] = (CH_DOUT[g*DOUT_WIDTH + DOUT_WIDTH-8 +: 8] == HDR);
  end

  assign cand    = CH_VALID & CH_ENABLE & isHdr;
  assign anyCand = |cand;
  // Rotate so bit 0 is the channel after the last grant; first set bit wins.
  assign candRot = CH_NUM'({cand, cand} >> (int'(grantId) + 1));

  always_comb begin
    rrFound = 1'b0;
    rrPick  = grantId;
    for (int j = 0; j < CH_NUM; j++) begin
      if (!rrFound && candRot[j]) begin
        rrFound = 1'b1;
        rrPick  = 3'((int'(grantId) + 1 + j) % CH_NUM);
      end
    end
  end

  always_comb begin
    strayHit = 1'b0;
    strayIdx = '0;
    for (int j = CH_NUM-1; j >= 0; j--) begin
      if (CH_VALID[j] && CH_ENABLE[j] && !isHdr[j]) begin
        strayHit = 1'b1;
        strayIdx = 3'(j);
      end
    end
  end

  assign grantOneHot = CH_NUM'(1) << grantId;
  assign strayOneHot = CH_NUM'(1) << strayIdx;
  assign grantValid  = |(CH_VALID & grantOneHot);
  assign grantWord   = DOUT_WIDTH'(CH_DOUT >> (int'(grantId) * DOUT_WIDTH));
  assign isFooter    = (grantWord[DOUT_WIDTH-1 -: 8] == FTR);
  assign wordCntInc  = wordCnt + 1'b1;
  assign wdExpire    = (wordCntInc == CNT_W'(MAX_FRAME_WORDS));

  always_comb begin
    stateNext = state;
    grantNext = grantId;
    readyVec  = '0;
    accept    = 1'b0;
    strayTake = 1'b0;
    case (state)
      IDLE: begin
        if (anyCand) begin
          grantNext = rrPick;
          stateNext = STREAM;
        end else if (strayHit) begin
          readyVec  = strayOneHot;
          strayTake = 1'b1;
        end
      end
      STREAM: begin
        if (!tVld_p1 || M_AXIS_TREADY) readyVec = grantOneHot;
        accept = grantValid && (!tVld_p1 || M_AXIS_TREADY);
        if (accept && (isFooter || wdExpire)) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Stray draining is combinational from inputs, so hold it off while reset is low.
  assign CH_READY = M_AXIS_ARESETN ? readyVec : '0;

  // p0 -> p1: accepted channel word into the output register
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state    <= IDLE;
      grantId  <= 3'(CH_NUM - 1);
      wordCnt  <= '0;
      tData_p1 <= '0;
      tVld_p1  <= 1'b0;
      tLast_p1 <= 1'b0;
      frameCnt <= '0;
      errCnt   <= '0;
    end else begin
      state   <= stateNext;
      grantId <= grantNext;
      if (state == IDLE) begin
        wordCnt <= '0;
        if (strayTake) errCnt <= satInc16(errCnt);
      end
      if (accept) begin
        tData_p1 <= grantWord;
        tVld_p1  <= 1'b1;
        tLast_p1 <= isFooter || wdExpire;
        wordCnt  <= wordCntInc;
        if (isFooter)      frameCnt <= frameCnt + 32'd1;
        else if (wdExpire) errCnt   <= satInc16(errCnt);
      end else if (M_AXIS_TREADY) begin
        tVld_p1  <= 1'b0;
        tLast_p1 <= 1'b0;
      end
    end
  end

  assign M_AXIS_TDATA  = tData_p1;
  assign M_AXIS_TVALID = tVld_p1;
  assign M_AXIS_TLAST  = tLast_p1;
  assign GRANT_ID      = grantId;
  assign FRAME_CNT     = frameCnt;
  assign ERR_CNT       = errCnt;

endmodule
